// File: rtl/ccff_pkg.sv
// Shared types and helpers for the configuration-chain loader.
package ccff_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_PRELOAD,
    ST_SHIFT,
    ST_DONE
  } ccff_state_t;

  localparam logic [7:0] CCFF_SENTINEL = 8'hA5;
  localparam int         CCFF_SENT_LEN = 8;

  // Width of a counter that must hold every value from 0 to max_val inclusive.
  function automatic int cnt_w(input int max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/ccff_piso.sv
// Parallel-in / serial-out word register for the configuration loader.
// Holds one bitstream word, presents its MSB, and tracks how many bits of
// the word are still to be shifted (sh_cnt).
module ccff_piso
  import ccff_pkg::*;
#(
  parameter int WORD_W = 32,
  parameter int SW     = cnt_w(WORD_W)
) (
  input  logic              prog_clk,
  input  logic              prog_reset,
  input  logic              load,
  input  logic              shift,
  input  logic [WORD_W-1:0] data,
  input  logic [SW-1:0]     cnt_init,
  output logic              msb,
  output logic [SW-1:0]     sh_cnt
);

  logic [WORD_W-1:0] sreg;

  // Load a fresh word with its bit budget, or shift left one bit per cycle.
  always_ff @(posedge prog_clk or posedge prog_reset) begin
    if (prog_reset) begin
      sreg   <= '0;
      sh_cnt <= '0;
    end else if (load) begin
      sreg   <= data;
      sh_cnt <= cnt_init;
    end else if (shift) begin
      sreg   <= {sreg[WORD_W-2:0], 1'b0};
      sh_cnt <= sh_cnt - SW'(1);
    end
  end

  assign msb = sreg[WORD_W-1];

endmodule

// File: rtl/ccff_bitstream_loader.sv
// Configuration chain writer: accepts bitstream words over valid/ready and
// serialises them MSB first onto ccff_head with an aligned ccff_shift_en.
// Optional build macro CCFF_TAIL_CHECK_EN adds an 8-bit sentinel preamble
// whose arrival at ccff_tail is checked to prove chain continuity.
//
// state      | meaning
// -----------+-----------------------------------------------------------
// ST_IDLE    | out of reset, waiting for cfg_start
// ST_LOAD    | cfg_ready high, waiting for the next word
// ST_PRELOAD | shifting the sentinel ahead of the data (check build only)
// ST_SHIFT   | shifting the current word, one bit per cycle
// ST_DONE    | chain fully loaded, cfg_done held; cfg_start reloads
module ccff_bitstream_loader
  import ccff_pkg::*;
#(
  parameter int         CHAIN_LEN = 1024,
  parameter int         WORD_W    = 32,
  parameter logic [7:0] SENTINEL  = CCFF_SENTINEL
) (
  input  logic              prog_clk,
  input  logic              prog_reset,
  input  logic              cfg_start,
  input  logic [WORD_W-1:0] cfg_data,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  output logic              ccff_head,
  output logic              ccff_shift_en,
  input  logic              ccff_tail,
  output logic              cfg_done,
  output logic              cfg_error
);

  localparam int BW = cnt_w(CHAIN_LEN);
  localparam int SW = cnt_w(WORD_W);

  ccff_state_t   state;
  logic [BW-1:0] bit_cnt;
  logic [SW-1:0] sh_cnt;
  logic [SW-1:0] sh_init;
  logic          piso_load;
  logic          piso_shift;
  logic          piso_msb;
  logic          start_take;

`ifdef CCFF_TAIL_CHECK_EN
  logic [7:0] pre_sr;
  logic [3:0] pre_cnt;
`endif

  assign start_take = cfg_start && ((state == ST_IDLE) || (state == ST_DONE));
  assign piso_load  = (state == ST_LOAD) && cfg_valid && cfg_ready;
  assign piso_shift = (state == ST_SHIFT);

  // Bits to take from the next word: a full word, or whatever the chain still needs.
  always_comb begin
    if ((CHAIN_LEN - int'(bit_cnt)) < WORD_W) sh_init = SW'(CHAIN_LEN - int'(bit_cnt));
    else                                      sh_init = SW'(WORD_W);
  end

  ccff_piso #(
    .WORD_W (WORD_W),
    .SW     (SW)
  ) u_piso (
    .prog_clk   (prog_clk),
    .prog_reset (prog_reset),
    .load       (piso_load),
    .shift      (piso_shift),
    .data       (cfg_data),
    .cnt_init   (sh_init),
    .msb        (piso_msb),
    .sh_cnt     (sh_cnt)
  );

  // Sequencing FSM; head and shift enable are registered together so each
  // bit and its enable reach the chain on the same edge.
  always_ff @(posedge prog_clk or posedge prog_reset) begin
    if (prog_reset) begin
      state         <= ST_IDLE;
      cfg_ready     <= 1'b0;
      ccff_head     <= 1'b0;
      ccff_shift_en <= 1'b0;
      cfg_done      <= 1'b0;
      bit_cnt       <= '0;
`ifdef CCFF_TAIL_CHECK_EN
      pre_sr        <= '0;
      pre_cnt       <= '0;
`endif
    end else begin
      ccff_shift_en <= 1'b0;
      case (state)
        ST_IDLE, ST_DONE: begin
          if (cfg_start) begin
            state     <= ST_LOAD;
            cfg_ready <= 1'b1;
            cfg_done  <= 1'b0;
            bit_cnt   <= '0;
          end else if (state == ST_DONE) begin
            cfg_done <= 1'b1;
          end
        end
        ST_LOAD: begin
          if (piso_load) begin
            cfg_ready <= 1'b0;
`ifdef CCFF_TAIL_CHECK_EN
            if (bit_cnt == '0) begin
              state   <= ST_PRELOAD;
              pre_sr  <= SENTINEL;
              pre_cnt <= 4'd8;
            end else begin
              state <= ST_SHIFT;
            end
`else
            state <= ST_SHIFT;
`endif
          end
        end
        ST_PRELOAD: begin
`ifdef CCFF_TAIL_CHECK_EN
          ccff_head     <= pre_sr[7];
          ccff_shift_en <= 1'b1;
          pre_sr        <= {pre_sr[6:0], 1'b0};
          pre_cnt       <= pre_cnt - 4'd1;
          if (pre_cnt == 4'd1) state <= ST_SHIFT;
`else
          state <= ST_IDLE;
`endif
        end
        ST_SHIFT: begin
          ccff_head     <= piso_msb;
          ccff_shift_en <= 1'b1;
          bit_cnt       <= bit_cnt + BW'(1);
          if (sh_cnt == SW'(1)) begin
            if (bit_cnt == BW'(CHAIN_LEN - 1)) begin
              state <= ST_DONE;
            end else begin
              state     <= ST_LOAD;
              cfg_ready <= 1'b1;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

`ifdef CCFF_TAIL_CHECK_EN
  localparam int EW = cnt_w(CHAIN_LEN + CCFF_SENT_LEN);

  logic [EW-1:0] edge_cnt;
  logic          chk_pend;
  logic [7:0]    chk_sr;
  logic          in_window;

  // Sentinel bit i surfaces at the tail after chain edge CHAIN_LEN+i.
  assign in_window = chk_pend &&
                     (edge_cnt >= EW'(CHAIN_LEN)) &&
                     (edge_cnt <  EW'(CHAIN_LEN + CCFF_SENT_LEN));

  // Count chain edges and compare the tail in the cycle after each sentinel edge.
  always_ff @(posedge prog_clk or posedge prog_reset) begin
    if (prog_reset) begin
      edge_cnt  <= '0;
      chk_pend  <= 1'b0;
      chk_sr    <= '0;
      cfg_error <= 1'b0;
    end else if (start_take) begin
      edge_cnt  <= '0;
      chk_pend  <= 1'b0;
      chk_sr    <= SENTINEL;
      cfg_error <= 1'b0;
    end else begin
      chk_pend <= ccff_shift_en;
      if (ccff_shift_en) edge_cnt <= edge_cnt + EW'(1);
      if (in_window) begin
        chk_sr <= {chk_sr[6:0], 1'b0};
        if (ccff_tail != chk_sr[7]) cfg_error <= 1'b1;
      end
    end
  end
`else
  logic unused_ok;
  assign cfg_error = 1'b0;
  assign unused_ok = &{1'b0, ccff_tail, SENTINEL, start_take};
`endif

endmodule
